lcd_char_responder: RTL and testbench

Synthesizable HD44780-compatible character-LCD responder: the device end of the 8-bit parallel LCD bus driven by the NIOS system's LCD control slave (`LCD_E`, `LCD_RS`, `LCD_RW`, `LCD_data`).
- Decodes instruction and data writes, serves status and data reads, maintains an 80-byte DDRAM, and models the busy flag with programmable busy times.
- Used as an on-FPGA display model for hardware-in-loop checks of the LCD driver software, and as the bus responder in system simulation.
- Exposes a monitor port so display contents can be inspected.

---
 rtl/lcd_char_responder.sv | 219 +++++++++++++++++++++
 tb/tb_lcd_char_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_char_responder.sv
// HD44780-compatible character-LCD bus responder: 8-bit parallel bus slave with
// 80-byte DDRAM, programmable busy timing, clear engine and a DDRAM monitor port.
module lcd_char_responder #(
    parameter int unsigned BUSY_CYCLES      = 1850,
    parameter int unsigned LONG_BUSY_CYCLES = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       LCD_E,
    input  logic       LCD_RS,
    input  logic       LCD_RW,
    inout  wire  [7:0] LCD_data,
    input  logic [6:0] mon_addr,
    output logic [7:0] mon_data,
    output logic [6:0] ac,
    output logic       busy,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       entry_inc,
    output logic       two_line,
    output logic       proto_err
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        CLEAR,
        BUSY_WAIT
    } state_t;

    localparam int unsigned DDRAM_DEPTH = 80;
    localparam logic [6:0]  LAST_IDX    = 7'd79;
    localparam logic [2:0]  MIN_PULSE   = 3'd4;
    localparam logic [7:0]  BLANK       = 8'h20;

    function automatic logic ac_valid(input logic [6:0] a);
        return (a <= 7'h27) || ((a >= 7'h40) && (a <= 7'h67));
    endfunction

    // Row 1 (0x40..0x67) maps onto indices 40..79: subtract 0x40, add 40.
    function automatic logic [6:0] ac_index(input logic [6:0] a);
        return a[6] ? (a - 7'd24) : a;
    endfunction

    function automatic logic [6:0] ac_step(input logic [6:0] a, input logic up);
        if (up) begin
            if (a == 7'h27) return 7'h40;
            if (a == 7'h67) return 7'h00;
            return a + 7'd1;
        end
        if (a == 7'h40) return 7'h27;
        if (a == 7'h00) return 7'h67;
        return a - 7'd1;
    endfunction

    logic        e_s1, e_s2, e_s3;
    logic        e_rise, e_fall;
    logic        cap_rs, cap_rw;
    logic [7:0]  cap_data;
    logic        drive_en;
    logic [7:0]  rd_data;
    logic [31:0] busy_cnt;
    logic        clear_active;
    logic        clear_long;
    logic [6:0]  clr_idx;
    logic [2:0]  hi_len, lo_len;
    state_t      state;
    logic [7:0]  ddram [DDRAM_DEPTH];

    logic wr_fall, wr_accept, data_wr, instr_wr, rd_advance;

    assign e_rise     = e_s2 & ~e_s3;
    assign e_fall     = ~e_s2 & e_s3;
    assign wr_fall    = e_fall & ~cap_rw;
    assign wr_accept  = wr_fall & ~busy;
    assign data_wr    = wr_accept & cap_rs;
    assign instr_wr   = wr_accept & ~cap_rs;
    assign rd_advance = e_fall & cap_rw & cap_rs;

    assign busy     = (busy_cnt != 32'd0) | clear_active;
    assign LCD_data = drive_en ? (cap_rs ? rd_data : {busy, ac}) : 8'hzz;

    always_ff @(posedge clk) begin
        if (reset) begin
            e_s1 <= 1'b0;
            e_s2 <= 1'b0;
            e_s3 <= 1'b0;
        end else begin
            e_s1 <= LCD_E;
            e_s2 <= e_s1;
            e_s3 <= e_s2;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_active) begin
            ddram[clr_idx] <= BLANK;
        end else if (data_wr) begin
            ddram[ac_index(ac)] <= cap_data;
        end
        if (e_rise) begin
            rd_data <= ddram[ac_index(ac)];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            ac           <= '0;
            display_on   <= 1'b0;
            cursor_on    <= 1'b0;
            blink_on     <= 1'b0;
            entry_inc    <= 1'b1;
            two_line     <= 1'b0;
            proto_err    <= 1'b0;
            busy_cnt     <= '0;
            clear_active <= 1'b1;
            clear_long   <= 1'b0;
            clr_idx      <= '0;
            cap_rs       <= 1'b0;
            cap_rw       <= 1'b0;
            cap_data     <= '0;
            drive_en     <= 1'b0;
            hi_len       <= '1;
            lo_len       <= '1;
            mon_data     <= '0;
        end else begin
            mon_data <= (mon_addr < 7'd80) ? ddram[mon_addr] : 8'h00;

            if (e_rise) begin
                cap_rs   <= LCD_RS;
                cap_rw   <= LCD_RW;
                cap_data <= LCD_data;
                drive_en <= LCD_RW;
                hi_len   <= 3'd1;
                if (lo_len < MIN_PULSE) proto_err <= 1'b1;
                if (LCD_RW && LCD_RS && busy) proto_err <= 1'b1;
            end else if (e_s2) begin
                hi_len <= (hi_len == 3'd7) ? hi_len : hi_len + 3'd1;
            end

            if (e_fall) begin
                drive_en <= 1'b0;
                lo_len   <= 3'd1;
                if (hi_len < MIN_PULSE) proto_err <= 1'b1;
            end else if (!e_s2) begin
                lo_len <= (lo_len == 3'd7) ? lo_len : lo_len + 3'd1;
            end

            if (busy_cnt != 32'd0) busy_cnt <= busy_cnt - 32'd1;

            // Clear engine: one blank per cycle; a commanded clear then runs the long busy time.
            if (clear_active) begin
                clr_idx <= clr_idx + 7'd1;
                if (clr_idx == LAST_IDX) begin
                    clear_active <= 1'b0;
                    if (clear_long) busy_cnt <= LONG_BUSY_CYCLES;
                end
            end

            if (wr_fall && busy) proto_err <= 1'b1;

            if (rd_advance) ac <= ac_step(ac, entry_inc);

            if (data_wr) begin
                ac       <= ac_step(ac, entry_inc);
                busy_cnt <= BUSY_CYCLES;
            end

            if (instr_wr) begin
                busy_cnt <= BUSY_CYCLES;
                casez (cap_data)
                    8'b1???????: begin
                        if (ac_valid(cap_data[6:0])) ac <= cap_data[6:0];
                        else proto_err <= 1'b1;
                    end
                    8'b01??????: ;
                    8'b001?????: begin
                        two_line <= cap_data[3];
                        if (!cap_data[4]) proto_err <= 1'b1;
                    end
                    8'b0001????: begin
                        if (!cap_data[3]) ac <= ac_step(ac, cap_data[2]);
                    end
                    8'b00001???: begin
                        display_on <= cap_data[2];
                        cursor_on  <= cap_data[1];
                        blink_on   <= cap_data[0];
                    end
                    8'b000001??: entry_inc <= cap_data[1];
                    8'b0000001?: begin
                        ac       <= '0;
                        busy_cnt <= LONG_BUSY_CYCLES;
                    end
                    8'b00000001: begin
                        ac           <= '0;
                        entry_inc    <= 1'b1;
                        busy_cnt     <= '0;
                        clear_active <= 1'b1;
                        clear_long   <= 1'b1;
                        clr_idx      <= '0;
                    end
                    default: busy_cnt <= '0;
                endcase
            end

            case (state)
                IDLE:      ;
                EXEC:      state <= clear_active ? CLEAR : BUSY_WAIT;
                CLEAR:     if (clr_idx == LAST_IDX) state <= BUSY_WAIT;
                BUSY_WAIT: if (!clear_active && busy_cnt <= 32'd1) state <= IDLE;
                default:   state <= IDLE;
            endcase
            if (wr_accept && !(instr_wr && cap_data == 8'h00)) state <= EXEC;
        end
    end

endmodule

// File: tb/tb_lcd_char_responder.sv
// Directed + randomized bench for lcd_char_responder against a position-based
// display model (linear cursor 0..79, busy durations from the instruction set).
module tb_lcd_char_responder;

    localparam int unsigned BUSY_T = 20;
    localparam int unsigned LONG_T = 60;

    logic       clk = 1'b0;
    logic       reset;
    logic       LCD_E, LCD_RS, LCD_RW;
    logic       tb_oe;
    logic [7:0] tb_val;
    wire  [7:0] LCD_data;
    logic [6:0] mon_addr;
    logic [7:0] mon_data;
    logic [6:0] ac;
    logic       busy, display_on, cursor_on, blink_on, entry_inc, two_line, proto_err;

    assign LCD_data = tb_oe ? tb_val : 8'hzz;

    lcd_char_responder #(
        .BUSY_CYCLES     (BUSY_T),
        .LONG_BUSY_CYCLES(LONG_T)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .LCD_E     (LCD_E),
        .LCD_RS    (LCD_RS),
        .LCD_RW    (LCD_RW),
        .LCD_data  (LCD_data),
        .mon_addr  (mon_addr),
        .mon_data  (mon_data),
        .ac        (ac),
        .busy      (busy),
        .display_on(display_on),
        .cursor_on (cursor_on),
        .blink_on  (blink_on),
        .entry_inc (entry_inc),
        .two_line  (two_line),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_ram [80];
    int         m_pos;
    bit         m_inc, m_disp, m_cur, m_blink, m_two, m_err;

    function automatic logic [6:0] m_ac();
        return (m_pos < 40) ? 7'(m_pos) : 7'(m_pos - 40 + 64);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_inc = 1; m_disp = 0; m_cur = 0; m_blink = 0; m_two = 0; m_err = 0;
        for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
    endtask

    task automatic model_write(input bit rs, input logic [7:0] d, output int exp_busy);
        int a;
        exp_busy = BUSY_T;
        a = int'(d[6:0]);
        if (rs) begin
            m_ram[m_pos] = d;
            m_pos = m_inc ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
        end else if (d[7]) begin
            if (a < 40) m_pos = a;
            else if (a >= 64 && a < 104) m_pos = a - 64 + 40;
            else m_err = 1;
        end else if (d[6]) begin
        end else if (d[5]) begin
            m_two = d[3];
            if (!d[4]) m_err = 1;
        end else if (d[4]) begin
            if (!d[3]) m_pos = d[2] ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
        end else if (d[3]) begin
            m_disp = d[2]; m_cur = d[1]; m_blink = d[0];
        end else if (d[2]) begin
            m_inc = d[1];
        end else if (d[1]) begin
            m_pos = 0;
            exp_busy = LONG_T;
        end else if (d[0]) begin
            for (int i = 0; i < 80; i++) m_ram[i] = 8'h20;
            m_pos = 0; m_inc = 1;
            exp_busy = 80 + LONG_T;
        end else begin
            exp_busy = 0;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ac"}, ac, m_ac());
        chk({tag, "_flags"}, {display_on, cursor_on, blink_on, entry_inc, two_line, proto_err},
            {m_disp, m_cur, m_blink, m_inc, m_two, m_err});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", busy, 0);
    endtask

    task automatic pulse(input bit rs, input logic [7:0] d);
        LCD_RS = rs; LCD_RW = 0; tb_val = d; tb_oe = 1;
        repeat (5) @(negedge clk);
        LCD_E = 1;
        repeat (6) @(negedge clk);
        LCD_E = 0;
        tb_oe = 0;
    endtask

    task automatic do_write(input bit rs, input logic [7:0] d, input string tag);
        int exp_busy, first, cnt;
        wait_idle();
        model_write(rs, d, exp_busy);
        pulse(rs, d);
        first = -1;
        cnt = 0;
        for (int i = 0; i < exp_busy + 12; i++) begin
            @(negedge clk);
            if (busy) begin
                cnt++;
                if (first < 0) first = i;
            end
        end
        chk({tag, "_busy_len"}, cnt, exp_busy);
        if (exp_busy > 0) chk({tag, "_busy_rise"}, first, 2);
        check_state(tag);
    endtask

    task automatic read_bus(input bit rs, input bit idle_first, output logic [7:0] val);
        if (idle_first) wait_idle();
        LCD_RS = rs; LCD_RW = 1; tb_oe = 0;
        repeat (5) @(negedge clk);
        LCD_E = 1;
        repeat (4) @(negedge clk);
        val = LCD_data;
        repeat (2) @(negedge clk);
        LCD_E = 0;
        repeat (4) @(negedge clk);
        LCD_RW = 0;
    endtask

    task automatic do_reset();
        int cnt;
        reset = 1; LCD_E = 0; LCD_RW = 0; tb_oe = 0;
        @(negedge clk);
        chk("reset_mon_data", mon_data, 0);
        chk("reset_ac", ac, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        model_reset();
        cnt = busy ? 1 : 0;
        for (int i = 0; i < 95; i++) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        chk("reset_busy_len", cnt, 80);
        check_state("reset");
    endtask

    task automatic check_ram(input string tag);
        for (int i = 0; i < 80; i++) begin
            mon_addr = 7'(i);
            @(negedge clk);
            chk({tag, "_ram"}, mon_data, m_ram[i]);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] v;
        int op, p;
        reset = 1; LCD_E = 0; LCD_RS = 0; LCD_RW = 0; tb_oe = 0; tb_val = 0; mon_addr = 0;

        do_reset();
        check_ram("t1");

        do_write(0, 8'h06, "t2_entry");
        do_write(0, 8'hA7, "t2_addr");
        do_write(1, 8'h41, "t2_d41");
        do_write(1, 8'h42, "t2_d42");

        do_write(0, 8'h04, "t3_entry");
        do_write(0, 8'h80, "t3_addr");
        do_write(1, 8'h55, "t3_d55");

        do_write(0, 8'h38, "fset");
        do_write(0, 8'h00, "nop");
        do_write(0, 8'h14, "shift_r");
        do_write(0, 8'h10, "shift_l");
        do_write(0, 8'h1C, "shift_disp");
        do_write(0, 8'h02, "home");

        model_write(0, 8'h0F, op);
        pulse(0, 8'h0F);
        read_bus(0, 0, v);
        chk("t4_status_busy", v, {1'b1, m_ac()});
        read_bus(0, 1, v);
        chk("t4_status_idle", v, {1'b0, m_ac()});
        check_state("t4");

        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 5);
            case (op)
                0, 1: do_write(1, 8'($urandom_range(8'h21, 8'h7e)), "rnd_data");
                2: begin
                    p = $urandom_range(0, 79);
                    do_write(0, 8'h80 | ((p < 40) ? 8'(p) : 8'(p - 40 + 64)), "rnd_addr");
                end
                3: do_write(0, 8'h04 | 8'($urandom_range(0, 1) << 1), "rnd_entry");
                4: do_write(0, 8'h10 | 8'($urandom_range(0, 1) << 2), "rnd_shift");
                default: begin
                    read_bus(1, 1, v);
                    chk("rnd_dread", v, m_ram[m_pos]);
                    m_pos = m_inc ? (m_pos + 1) % 80 : (m_pos + 79) % 80;
                    check_state("rnd_dread");
                end
            endcase
        end
        check_ram("rnd");

        model_write(0, 8'h06, op);
        pulse(0, 8'h06);
        m_err = 1;
        pulse(1, 8'h33);
        wait_idle();
        check_state("t5");
        check_ram("t5");
        do_write(0, 8'h0C, "t5_sticky");

        do_write(0, 8'h95, "t6_addr");
        do_write(0, 8'h01, "t6_clear");
        check_ram("t6");
        do_write(1, 8'h5A, "t6_post");
        model_write(0, 8'h01, op);
        pulse(0, 8'h01);
        repeat (30) @(negedge clk);
        do_reset();
        check_ram("t6_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
